// File: rtl/note_lane_renderer.sv
// note_lane_renderer: on each start it clears the lane region, then streams every active
// note sprite to the VGA plot interface. It emits one pixel per clock from a snapshot of the note inputs.
module note_lane_renderer #(
   parameter int         NUM_NOTES = 15,
   parameter int         SPRITE_W  = 2,
   parameter int         SPRITE_H  = 8,
   parameter int         LANE_Y    = 110,
   parameter int         SCREEN_W  = 160,
   parameter int         CLR_X0    = 0,
   parameter int         CLR_X1    = 159,
   parameter int         CLR_Y0    = 100,
   parameter int         CLR_Y1    = 119,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic                   CLK,
   input  logic                   reset,
   input  logic                   start,
   input  logic [8*NUM_NOTES-1:0] note_x,
   input  logic [3*NUM_NOTES-1:0] note_colour,
   input  logic [NUM_NOTES-1:0]   note_valid,
   output logic [7:0]             OutX,
   output logic [6:0]             OutY,
   output logic [2:0]             colour_to_draw,
   output logic                   plot,
   output logic                   busy,
   output logic                   done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_SCAN  = 3'd2;
   localparam logic [2:0] S_DRAW  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);

   generate
      if (LANE_Y + SPRITE_H - 1 > 119) begin : g_bad_lane
         $error("note_lane_renderer: sprite rows extend past row 119");
      end
      if (!(CLR_X1 < SCREEN_W && SCREEN_W <= 256)) begin : g_bad_screen
         $error("note_lane_renderer: need CLR_X1 < SCREEN_W <= 256");
      end
      if (CLR_X0 > CLR_X1) begin : g_bad_clr_x
         $error("note_lane_renderer: need CLR_X0 <= CLR_X1");
      end
      if (!(CLR_Y0 <= CLR_Y1 && CLR_Y1 <= 127)) begin : g_bad_clr_y
         $error("note_lane_renderer: need CLR_Y0 <= CLR_Y1 <= 127");
      end
   endgenerate

   logic [2:0]             state;
   logic [7:0]             cx;
   logic [6:0]             cy;
   logic [IDX_W-1:0]       idx;
   logic [7:0]             dx;
   logic [6:0]             dy;
   logic [8*NUM_NOTES-1:0] snap_x;
   logic [3*NUM_NOTES-1:0] snap_colour;
   logic [NUM_NOTES-1:0]   snap_valid;
   logic [7:0]             sel_x;
   logic [2:0]             sel_colour;
   logic                   sel_valid;
   logic [8:0]             draw_sum;

   // Slot selection; the 9-bit sum lets sprites that run past the screen edge be detected
   always_comb begin
      sel_x      = snap_x[{idx, 3'b000} +: 8];
      sel_colour = snap_colour[32'd3 * idx +: 3];
      sel_valid  = snap_valid[idx];
      draw_sum   = {1'b0, sel_x} + {1'b0, dx};
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         cx             <= 8'd0;
         cy             <= 7'd0;
         idx            <= '0;
         dx             <= 8'd0;
         dy             <= 7'd0;
         snap_x         <= '0;
         snap_colour    <= '0;
         snap_valid     <= '0;
         OutX           <= 8'd0;
         OutY           <= 7'd0;
         colour_to_draw <= 3'd0;
         plot           <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               plot <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  snap_x      <= note_x;
                  snap_colour <= note_colour;
                  snap_valid  <= note_valid;
                  cx          <= 8'(CLR_X0);
                  cy          <= 7'(CLR_Y0);
                  busy        <= 1'b1;
                  state       <= S_CLEAR;
               end else begin
                  busy <= 1'b0;
               end
            end
            S_CLEAR: begin
               OutX           <= cx;
               OutY           <= cy;
               colour_to_draw <= BG_COLOUR;
               plot           <= 1'b1;
               if (cx == 8'(CLR_X1)) begin
                  cx <= 8'(CLR_X0);
                  if (cy == 7'(CLR_Y1)) begin
                     idx   <= '0;
                     state <= S_SCAN;
                  end else begin
                     cy <= cy + 7'd1;
                  end
               end else begin
                  cx <= cx + 8'd1;
               end
            end
            S_SCAN: begin
               plot <= 1'b0;
               if (sel_valid) begin
                  dx    <= 8'd0;
                  dy    <= 7'd0;
                  state <= S_DRAW;
               end else if (idx == LAST_IDX) begin
                  state <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DRAW: begin
               // Off-screen pixels keep their cycle but are not plotted
               OutX           <= draw_sum[7:0];
               OutY           <= 7'(LANE_Y) + dy;
               colour_to_draw <= sel_colour;
               plot           <= (draw_sum < 9'(SCREEN_W));
               if (dx == 8'(SPRITE_W - 1)) begin
                  dx <= 8'd0;
                  if (dy == 7'(SPRITE_H - 1)) begin
                     if (idx == LAST_IDX) begin
                        state <= S_DONE;
                     end else begin
                        idx   <= idx + 1'b1;
                        state <= S_SCAN;
                     end
                  end else begin
                     dy <= dy + 7'd1;
                  end
               end else begin
                  dx <= dx + 8'd1;
               end
            end
            S_DONE: begin
               plot  <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               plot  <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_lane_renderer.sv
// Self-checking bench for note_lane_renderer: randomized note sets compared cycle by cycle
// against a reference list of expected busy-cycle outputs built from the frame rules.
module tb_note_lane_renderer;

   localparam int NN      = 15;
   localparam int CLR_PIX = 3200;

   logic            CLK         = 1'b0;
   logic            reset       = 1'b1;
   logic            start       = 1'b0;
   logic [8*NN-1:0] note_x      = '0;
   logic [3*NN-1:0] note_colour = '0;
   logic [NN-1:0]   note_valid  = '0;
   logic [7:0]      OutX;
   logic [6:0]      OutY;
   logic [2:0]      colour_to_draw;
   logic            plot;
   logic            busy;
   logic            done;

   typedef struct packed {
      logic       plot;
      logic       chk;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   pix_t exp_q[$];
   pix_t obs_q[$];
   int   tests = 0;
   int   fails = 0;
   logic done_ok;
   int   extra_done;

   always #5 CLK = ~CLK;

   note_lane_renderer dut (
      .CLK(CLK), .reset(reset), .start(start),
      .note_x(note_x), .note_colour(note_colour), .note_valid(note_valid),
      .OutX(OutX), .OutY(OutY), .colour_to_draw(colour_to_draw),
      .plot(plot), .busy(busy), .done(done)
   );

   function automatic pix_t mk(logic p, logic k, logic [7:0] x, logic [6:0] y, logic [2:0] c);
      pix_t r;
      r.plot = p; r.chk = k; r.x = x; r.y = y; r.c = c;
      return r;
   endfunction

   function automatic logic [8*NN-1:0] rand_x();
      return 120'({$urandom, $urandom, $urandom, $urandom});
   endfunction

   function automatic logic [3*NN-1:0] rand_c();
      return 45'({$urandom, $urandom});
   endfunction

   // Every busy cycle: start acknowledge, clear raster, then one scan per slot plus its sprite
   task automatic build_model(input logic [8*NN-1:0] xs, input logic [3*NN-1:0] cs,
                              input logic [NN-1:0] vs);
      int s;
      exp_q.delete();
      exp_q.push_back(mk(1'b0, 1'b0, 8'd0, 7'd0, 3'd0));
      for (int y = 100; y <= 119; y++)
         for (int x = 0; x <= 159; x++)
            exp_q.push_back(mk(1'b1, 1'b1, 8'(x), 7'(y), 3'b000));
      for (int i = 0; i < NN; i++) begin
         exp_q.push_back(mk(1'b0, 1'b0, 8'd0, 7'd0, 3'd0));
         if (vs[i]) begin
            for (int dy = 0; dy < 8; dy++)
               for (int dx = 0; dx < 2; dx++) begin
                  s = int'(xs[8*i +: 8]) + dx;
                  exp_q.push_back(mk(s < 160, 1'b1, 8'(s), 7'(110 + dy), cs[3*i +: 3]));
               end
         end
      end
   endtask

   function automatic int first_diff();
      int n;
      n = (exp_q.size() < obs_q.size()) ? exp_q.size() : obs_q.size();
      for (int i = 0; i < n; i++) begin
         if (obs_q[i].plot !== exp_q[i].plot) return i;
         if (exp_q[i].chk && ({obs_q[i].x, obs_q[i].y, obs_q[i].c} !==
                              {exp_q[i].x, exp_q[i].y, exp_q[i].c})) return i;
      end
      if (exp_q.size() != obs_q.size()) return n;
      return -1;
   endfunction

   task automatic show_diff(input string name, input int d);
      pix_t o;
      pix_t e;
      o = (d < obs_q.size()) ? obs_q[d] : '0;
      e = (d < exp_q.size()) ? exp_q[d] : '0;
      $display("FAIL %s stream cycle %0d: got plot=%0b (%0d,%0d) c=%0d len=%0d, want plot=%0b (%0d,%0d) c=%0d len=%0d",
               name, d, o.plot, o.x, o.y, o.c, obs_q.size(), e.plot, e.x, e.y, e.c, exp_q.size());
   endtask

   // Called at a falling edge; pulses start, records outputs of every busy cycle
   task automatic run_frame(input logic [8*NN-1:0] xs, input logic [3*NN-1:0] cs,
                            input logic [NN-1:0] vs, input int poke_at, input int idle_after);
      int n;
      note_x = xs; note_colour = cs; note_valid = vs; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      obs_q.delete();
      n = 0;
      while (busy === 1'b1 && n < 4000) begin
         obs_q.push_back(mk(plot, 1'b0, OutX, OutY, colour_to_draw));
         if (n == poke_at) begin
            note_x = rand_x(); note_colour = rand_c(); note_valid = ~vs; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         n++;
         @(negedge CLK);
      end
      start = 1'b0;
      done_ok = (done === 1'b1) && (plot === 1'b0) && (busy === 1'b0);
      extra_done = 0;
      for (int i = 0; i < idle_after; i++) begin
         @(negedge CLK);
         if (done !== 1'b0 || busy !== 1'b0) extra_done++;
      end
   endtask

   task automatic test_reset();
      #12;
      tests++;
      if ({OutX, OutY, colour_to_draw, plot, busy, done} !== 21'd0) begin
         fails++;
         $display("FAIL reset_values got %h want 0", {OutX, OutY, colour_to_draw, plot, busy, done});
      end
      @(negedge CLK);
      reset = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_single_note();
      logic [8*NN-1:0] xs;
      logic [3*NN-1:0] cs;
      int d;
      xs = rand_x(); cs = rand_c();
      xs[7:0] = 8'd20; cs[2:0] = 3'b101;
      build_model(xs, cs, 15'h0001);
      run_frame(xs, cs, 15'h0001, -1, 2);
      tests++;
      if (obs_q.size() != 1 + CLR_PIX + NN + 16) begin
         fails++; $display("FAIL single_len busy=%0d want=%0d", obs_q.size(), 1 + CLR_PIX + NN + 16);
      end
      tests++;
      if (obs_q.size() < 3203 || obs_q[1] !== mk(1'b1, 1'b0, 8'd0, 7'd100, 3'd0) ||
          obs_q[3202] !== mk(1'b1, 1'b0, 8'd20, 7'd110, 3'b101)) begin
         fails++; $display("FAIL single_landmarks first clear / first sprite pixel wrong (len %0d)", obs_q.size());
      end
      d = first_diff();
      tests++;
      if (d != -1) begin fails++; show_diff("single", d); end
      tests++;
      if (!done_ok || extra_done != 0) begin
         fails++; $display("FAIL single_done ok=%0b extra=%0d want ok=1 extra=0", done_ok, extra_done);
      end
   endtask

   task automatic test_no_valid();
      logic [8*NN-1:0] xs;
      logic [3*NN-1:0] cs;
      int d;
      xs = rand_x(); cs = rand_c();
      build_model(xs, cs, 15'h0000);
      run_frame(xs, cs, 15'h0000, -1, 2);
      tests++;
      if (obs_q.size() != 1 + CLR_PIX + NN) begin
         fails++; $display("FAIL none_len busy=%0d want=%0d", obs_q.size(), 1 + CLR_PIX + NN);
      end
      d = first_diff();
      tests++;
      if (d != -1) begin fails++; show_diff("none", d); end
      tests++;
      if (!done_ok || extra_done != 0) begin
         fails++; $display("FAIL none_done ok=%0b extra=%0d want ok=1 extra=0", done_ok, extra_done);
      end
   endtask

   task automatic test_clip();
      logic [8*NN-1:0] xs;
      logic [3*NN-1:0] cs;
      int d;
      int edge_plots;
      xs = rand_x(); cs = rand_c();
      xs[31:24] = 8'd159;
      build_model(xs, cs, 15'h0008);
      run_frame(xs, cs, 15'h0008, -1, 2);
      edge_plots = 0;
      for (int i = CLR_PIX + 1; i < obs_q.size(); i++)
         if (obs_q[i].plot === 1'b1) edge_plots++;
      tests++;
      if (edge_plots != 8 || obs_q.size() != 1 + CLR_PIX + NN + 16) begin
         fails++; $display("FAIL clip_counts sprite plots=%0d len=%0d want 8 and %0d",
                           edge_plots, obs_q.size(), 1 + CLR_PIX + NN + 16);
      end
      d = first_diff();
      tests++;
      if (d != -1) begin fails++; show_diff("clip", d); end
      tests++;
      if (!done_ok) begin fails++; $display("FAIL clip_done ok=%0b want 1", done_ok); end
   endtask

   task automatic test_snapshot();
      logic [8*NN-1:0] xs;
      logic [3*NN-1:0] cs;
      logic [NN-1:0]   vs;
      int d;
      xs = rand_x(); cs = rand_c(); vs = 15'($urandom_range(1, 32767));
      build_model(xs, cs, vs);
      run_frame(xs, cs, vs, 100, 6);
      tests++;
      if (obs_q.size() != 1 + CLR_PIX + NN + 16 * $countones(vs)) begin
         fails++; $display("FAIL snapshot_len busy=%0d want=%0d", obs_q.size(), 1 + CLR_PIX + NN + 16 * $countones(vs));
      end
      d = first_diff();
      tests++;
      if (d != -1) begin fails++; show_diff("snapshot", d); end
      tests++;
      if (!done_ok || extra_done != 0) begin
         fails++; $display("FAIL snapshot_one_done ok=%0b extra=%0d want ok=1 extra=0", done_ok, extra_done);
      end
   endtask

   task automatic test_full_overlap();
      logic [8*NN-1:0] xs;
      logic [3*NN-1:0] cs;
      int d;
      logic [2:0] last_c;
      cs = rand_c();
      for (int i = 0; i < NN; i++) xs[8*i +: 8] = 8'($urandom_range(60, 255));
      xs[39:32] = 8'd50; xs[47:40] = 8'd50;
      cs[14:12] = 3'b010; cs[17:15] = 3'b100;
      build_model(xs, cs, 15'h7FFF);
      run_frame(xs, cs, 15'h7FFF, -1, 2);
      tests++;
      if (obs_q.size() != 1 + CLR_PIX + NN + 240) begin
         fails++; $display("FAIL full_len busy=%0d want=%0d", obs_q.size(), 1 + CLR_PIX + NN + 240);
      end
      last_c = 3'd0;
      for (int i = CLR_PIX + 1; i < obs_q.size(); i++)
         if (obs_q[i].plot === 1'b1 && obs_q[i].x == 8'd50 && obs_q[i].y == 7'd110) last_c = obs_q[i].c;
      tests++;
      if (last_c !== 3'b100) begin
         fails++; $display("FAIL overlap_winner last colour at (50,110)=%0d want 4", last_c);
      end
      d = first_diff();
      tests++;
      if (d != -1) begin fails++; show_diff("full", d); end
   endtask

   task automatic test_random();
      logic [8*NN-1:0] xs;
      logic [3*NN-1:0] cs;
      logic [NN-1:0]   vs;
      int d;
      for (int r = 0; r < 3; r++) begin
         xs = rand_x(); cs = rand_c(); vs = 15'($urandom);
         build_model(xs, cs, vs);
         run_frame(xs, cs, vs, -1, 2);
         d = first_diff();
         tests++;
         if (d != -1) begin fails++; show_diff("random", d); end
         tests++;
         if (!done_ok || extra_done != 0) begin
            fails++; $display("FAIL random_done ok=%0b extra=%0d want ok=1 extra=0", done_ok, extra_done);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [8*NN-1:0] xs;
      logic [3*NN-1:0] cs;
      logic [NN-1:0]   vs;
      int d;
      for (int r = 0; r < 2; r++) begin
         xs = rand_x(); cs = rand_c(); vs = 15'($urandom);
         build_model(xs, cs, vs);
         run_frame(xs, cs, vs, -1, (r == 1) ? 2 : 0);
         d = first_diff();
         tests++;
         if (d != -1 || !done_ok) begin
            fails++; $display("FAIL back_to_back frame %0d diff=%0d done_ok=%0b want -1 and 1", r, d, done_ok);
         end
      end
   endtask

   task automatic test_reset_mid_draw();
      logic [8*NN-1:0] xs;
      logic [3*NN-1:0] cs;
      logic [NN-1:0]   vs;
      int d;
      xs = rand_x(); cs = rand_c();
      xs[7:0] = 8'd20; cs[2:0] = 3'b101;
      note_x = xs; note_colour = cs; note_valid = 15'h0001; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (3205) @(negedge CLK);
      tests++;
      if ({plot, OutX, OutY, colour_to_draw} !== {1'b1, 8'd21, 7'd111, 3'b101}) begin
         fails++; $display("FAIL reach_draw got plot=%0b (%0d,%0d) c=%0d want plot=1 (21,111) c=5",
                           plot, OutX, OutY, colour_to_draw);
      end
      #2 reset = 1'b1;
      #1;
      tests++;
      if ({OutX, OutY, colour_to_draw, plot, busy, done} !== 21'd0) begin
         fails++; $display("FAIL reset_mid_draw got %h want 0", {OutX, OutY, colour_to_draw, plot, busy, done});
      end
      @(negedge CLK);
      reset = 1'b0;
      xs = rand_x(); cs = rand_c(); vs = 15'($urandom);
      build_model(xs, cs, vs);
      run_frame(xs, cs, vs, -1, 2);
      tests++;
      if (obs_q.size() < 2 || obs_q[1] !== mk(1'b1, 1'b0, 8'd0, 7'd100, 3'd0)) begin
         fails++; $display("FAIL after_reset_first_pixel len=%0d want first clear pixel (0,100)", obs_q.size());
      end
      d = first_diff();
      tests++;
      if (d != -1) begin fails++; show_diff("after_reset", d); end
   endtask

   initial begin
      test_reset();
      test_single_note();
      test_no_valid();
      test_clip();
      test_snapshot();
      test_full_overlap();
      test_random();
      test_back_to_back();
      test_reset_mid_draw();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
